// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: default widths, state
// encoding and the pattern-length saturation helper.
package seq_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_REP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // A length of 0, or one longer than the pattern register, means "use all of it".
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left-shift register holding the pattern MSB-aligned, with a
// down-counting bit counter that flags the final bit of the pattern.
module seq_gen_shreg #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic [PAT_W-1:0] load_pat,
    input  logic [LEN_W-1:0] load_len,
    output logic             bit_out,
    output logic             last_bit
);

    logic [PAT_W-1:0] sh_q;
    logic [LEN_W-1:0] cnt_q;

    // The used field pattern[len-1:0] is moved to the top so that the MSB of
    // the register is always the bit currently on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sh_q  <= load_pat << (PAT_W - int'(load_len));
            cnt_q <= load_len - LEN_W'(1);
        end else if (shift) begin
            sh_q <= {sh_q[PAT_W-2:0], 1'b0};
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end else if (clr) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end
    end

    assign bit_out  = sh_q[PAT_W-1];
    assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated
// a programmed number of times with an optional idle gap between repetitions.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for start; line quiet
//   ST_SHIFT | one pattern bit per clock on x_out, x_valid high
//   ST_GAP   | GAP_CYC quiet cycles between repetitions, still busy
//   ST_DONE  | single-cycle done pulse, start ignored
module seq_gen
    import seq_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int REP_W   = DEF_REP_W,
    parameter int GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] plen,
    input  logic [REP_W-1:0] reps,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = $clog2(GAP_CYC + 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    seq_state_t       state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [REP_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q;

    logic [LEN_W-1:0] plen_eff;
    logic [REP_W-1:0] reps_eff;
    logic [PAT_W-1:0] load_pat;
    logic [LEN_W-1:0] load_len;

    logic cap_en;
    logic sel_new;
    logic sh_load;
    logic sh_shift;
    logic sh_clr;
    logic rep_dec;
    logic gap_load;
    logic gap_dec;
    logic last_bit;

    assign plen_eff = LEN_W'(sat_len(32'(plen), PAT_W));
    assign reps_eff = (reps == '0) ? REP_W'(1) : reps;

    // The first load comes straight from the inputs; reloads use the captured copy.
    assign load_pat = sel_new ? pattern  : pat_q;
    assign load_len = sel_new ? plen_eff : len_q;

    always_comb begin
        state_d  = state_q;
        cap_en   = 1'b0;
        sel_new  = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clr   = 1'b0;
        rep_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cap_en  = 1'b1;
                    sel_new = 1'b1;
                    sh_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    sh_shift = 1'b1;
                end else if (rep_q > REP_W'(1)) begin
                    rep_dec = 1'b1;
                    if (GAP_CYC > 0) begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                        sh_clr   = 1'b1;
                    end else begin
                        sh_load = 1'b1;
                    end
                end else begin
                    state_d = ST_DONE;
                    sh_clr  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SHIFT;
                    sh_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with x_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_valid <= (state_d == ST_SHIFT);
            busy    <= (state_d == ST_SHIFT) || (state_d == ST_GAP);
            done    <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            rep_q <= '0;
            gap_q <= '0;
        end else begin
            if (cap_en) begin
                pat_q <= pattern;
                len_q <= plen_eff;
                rep_q <= reps_eff;
            end else if (rep_dec) begin
                rep_q <= rep_q - REP_W'(1);
            end

            if (gap_load) begin
                gap_q <= GAP_LOAD;
            end else if (gap_dec) begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

    seq_gen_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .clr      (sh_clr),
        .load_pat (load_pat),
        .load_len (load_len),
        .bit_out  (x_out),
        .last_bit (last_bit)
    );

endmodule
